// File: rtl/gpio_serial_loader_if.sv
// Bus between the GPIO serial loader, the housekeeping config registers and the pad control chains.
// The loader connects through the master modport; the register file and chains connect through slave.
interface gpio_serial_loader_if #(
  parameter int CFG_BITS = 13
);
  logic                start;
  logic                busy;
  logic                done;
  logic [5:0]          cfg_addr_1;
  logic [CFG_BITS-1:0] cfg_data_1;
  logic [5:0]          cfg_addr_2;
  logic [CFG_BITS-1:0] cfg_data_2;
  logic                serial_clock;
  logic                serial_load;
  logic                serial_data_1;
  logic                serial_data_2;

  modport master (
    input  start, cfg_data_1, cfg_data_2,
    output busy, done, cfg_addr_1, cfg_addr_2,
           serial_clock, serial_load, serial_data_1, serial_data_2
  );

  modport slave (
    output start, cfg_data_1, cfg_data_2,
    input  busy, done, cfg_addr_1, cfg_addr_2,
           serial_clock, serial_load, serial_data_1, serial_data_2
  );
endinterface

// File: rtl/gpio_serial_loader.sv
// Shifts every pad's config word down two GPIO control chains in parallel, far end first,
// then pulses serial_load so all pads take their new configuration together.
module gpio_serial_loader #(
  parameter int NUM_PADS = 19,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  gpio_serial_loader_if.master bus
);

  localparam int BIT_W = $clog2(CFG_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    FINISH
  } state_t;

  state_t              state_q;
  state_t              next_state;
  logic [3:0]          phase_q;
  logic [BIT_W-1:0]    bit_q;
  logic [5:0]          pad_q;
  logic [5:0]          pad_next;
  logic [CFG_BITS-1:0] shift_1_q;
  logic [CFG_BITS-1:0] shift_2_q;
  logic [5:0]          addr_1_q;
  logic [5:0]          addr_2_q;
  logic                busy_q;
  logic                done_q;
  logic                sclk_q;
  logic                sload_q;
  logic                sdata_1_q;
  logic                sdata_2_q;
  logic                timed;
  logic                phase_last;
  logic                bit_last;
  logic                pad_last;

  assign timed      = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == LOAD);
  assign phase_last = (phase_q == 4'(CLK_DIV - 1));
  assign bit_last   = (bit_q == BIT_W'(CFG_BITS - 1));
  assign pad_last   = (pad_q == 6'(NUM_PADS - 1));

  always_comb begin
    next_state = state_q;
    pad_next   = pad_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          next_state = FETCH;
          pad_next   = '0;
        end
      end
      FETCH: next_state = SHIFT_LO;
      SHIFT_LO: begin
        if (phase_last) next_state = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_last) begin
          if (!bit_last) begin
            next_state = SHIFT_LO;
          end else begin
            pad_next   = pad_q + 6'd1;
            next_state = pad_last ? LOAD : FETCH;
          end
        end
      end
      LOAD: begin
        if (phase_last) next_state = FINISH;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= next_state;
      pad_q   <= pad_next;
      phase_q <= (timed && !phase_last) ? phase_q + 4'd1 : 4'd0;
      if (state_q == IDLE) begin
        bit_q <= '0;
      end else if (state_q == SHIFT_HI && phase_last) begin
        bit_q <= bit_last ? '0 : bit_q + BIT_W'(1);
      end
    end
  end

  // Outputs are registered from next_state so every pin changes on the edge entering its state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sload_q   <= 1'b0;
      sdata_1_q <= 1'b0;
      sdata_2_q <= 1'b0;
      addr_1_q  <= '0;
      addr_2_q  <= '0;
      shift_1_q <= '0;
      shift_2_q <= '0;
    end else begin
      busy_q  <= (next_state != IDLE) && (next_state != FINISH);
      done_q  <= (next_state == FINISH);
      sclk_q  <= (next_state == SHIFT_HI);
      sload_q <= (next_state == LOAD);

      if (next_state == FETCH) begin
        addr_1_q <= 6'(NUM_PADS - 1) - pad_next;
        addr_2_q <= 6'(NUM_PADS) + pad_next;
      end

      if (state_q == FETCH) begin
        shift_1_q <= bus.cfg_data_1;
        shift_2_q <= bus.cfg_data_2;
        sdata_1_q <= bus.cfg_data_1[CFG_BITS-1];
        sdata_2_q <= bus.cfg_data_2[CFG_BITS-1];
      end else if (state_q == SHIFT_HI && phase_last) begin
        shift_1_q <= {shift_1_q[CFG_BITS-2:0], 1'b0};
        shift_2_q <= {shift_2_q[CFG_BITS-2:0], 1'b0};
        if (next_state == SHIFT_LO) begin
          sdata_1_q <= shift_1_q[CFG_BITS-2];
          sdata_2_q <= shift_2_q[CFG_BITS-2];
        end else if (next_state == LOAD) begin
          sdata_1_q <= 1'b0;
          sdata_2_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.cfg_addr_1    = addr_1_q;
  assign bus.cfg_addr_2    = addr_2_q;
  assign bus.serial_clock  = sclk_q;
  assign bus.serial_load   = sload_q;
  assign bus.serial_data_1 = sdata_1_q;
  assign bus.serial_data_2 = sdata_2_q;

  // Chains sample on the rising serial_clock, so data must never move while it is high.
  a_data_stable: assert property (@(posedge clock) disable iff (!resetn)
    sclk_q |-> ($stable(sdata_1_q) && $stable(sdata_2_q)));

  a_load_quiet: assert property (@(posedge clock) disable iff (!resetn)
    sload_q |-> (!sclk_q && busy_q && !done_q));

endmodule
